// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver:
// prefix codes, frame FSM states and key word layout.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  localparam int KB_BRK_BIT = 15;
  localparam int KB_EXT_BIT = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  function automatic logic [15:0] kb_word(
    input logic       brk,
    input logic       ext,
    input logic [7:0] code
  );
    logic [15:0] w;
    w             = '0;
    w[KB_BRK_BIT] = brk;
    w[KB_EXT_BIT] = ext;
    w[7:0]        = code;
    return w;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Pin synchroniser followed by a stability filter:
// the output flips only after FILTER_LEN cycles of disagreement.
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  // Count consecutive disagreements; flip once the run is long enough.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_s != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: deframes device-to-host frames,
// folds E0/F0 prefixes into key words and buffers them.
module ps2_kb_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        PS2_KBCLK,
  input  logic        PS2_KBDAT,
  output logic        KB_VALID,
  input  logic        KB_READY,
  output logic [15:0] KB_DATA,
  output logic        KB_PARITY_ERR,
  output logic        KB_FRAME_ERR,
  output logic        KB_OVERFLOW,
  input  logic        KB_ERR_CLR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic clk_f, dat_f;
  logic clk_prev_q;
  logic fall_q;

  ps2_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filt (
    .clk_i (CLOCK_50),
    .rst_ni(RESET_N),
    .pin_i (PS2_KBCLK),
    .filt_o(clk_f)
  );

  ps2_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_dat_filt (
    .clk_i (CLOCK_50),
    .rst_ni(RESET_N),
    .pin_i (PS2_KBDAT),
    .filt_o(dat_f)
  );

  // Registered falling-edge pulse of the filtered clock.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_prev_q <= clk_f;
      fall_q     <= clk_prev_q & ~clk_f;
    end
  end

  ps2_state_e     state_q, state_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           tmo_hit;
  logic           par_good;
  logic           frame_ok;
  logic           par_err_ev;
  logic           frm_err_ev;

  assign tmo_hit = (state_q != IDLE) &&
                   (tmo_q == TW'(TIMEOUT_CYC));

  // Frame deframing: next state, shift path and error events.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = '0;
    par_good   = ^{shift_q, par_q};
    frame_ok   = 1'b0;
    par_err_ev = 1'b0;
    frm_err_ev = 1'b0;
    if (state_q != IDLE && !fall_q) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (tmo_hit) begin
      state_d    = IDLE;
      tmo_d      = '0;
      frm_err_ev = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall_q && !dat_f) begin
            state_d = DATA;
            bit_d   = 3'd0;
          end
        end
        DATA: begin
          if (fall_q) begin
            shift_d = {dat_f, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (fall_q) begin
            par_d   = dat_f;
            state_d = STOP;
          end
        end
        STOP: begin
          if (fall_q) begin
            state_d    = IDLE;
            frm_err_ev = ~dat_f;
            par_err_ev = ~par_good;
            frame_ok   = dat_f & par_good;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame FSM state register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
    end
  end

  logic       frame_vld_q;
  logic [7:0] frame_code_q;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       dec_push;
  logic       is_ext, is_brk;

  // Hand a good frame to the decoder one cycle after the stop bit.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_vld_q  <= 1'b0;
      frame_code_q <= '0;
    end else begin
      frame_vld_q <= frame_ok;
      if (frame_ok) begin
        frame_code_q <= shift_q;
      end
    end
  end

  assign is_ext   = frame_code_q == PS2_EXT_PREFIX;
  assign is_brk   = frame_code_q == PS2_BRK_PREFIX;
  assign dec_push = frame_vld_q & ~is_ext & ~is_brk;

  // Prefix tracking: set on E0/F0, cleared by a key or a bad frame.
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    if (par_err_ev || frm_err_ev) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (frame_vld_q) begin
      if (is_ext) begin
        ext_d = 1'b1;
      end else if (is_brk) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Prefix flag registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [NW-1:0] cnt_q;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          ovf_ev;

  assign full     = cnt_q == NW'(FIFO_DEPTH);
  assign KB_VALID = cnt_q != '0;
  assign pop      = KB_VALID & KB_READY;
  assign push_ok  = dec_push & (~full | pop);
  assign ovf_ev   = dec_push & full & ~pop;
  assign KB_DATA  = KB_VALID ? mem_q[rd_q] : 16'h0000;

  // Key word FIFO: storage, pointers and occupancy.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= kb_word(brk_q, ext_q, frame_code_q);
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky error flags; a new event wins over a clear.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      KB_PARITY_ERR <= 1'b0;
      KB_FRAME_ERR  <= 1'b0;
      KB_OVERFLOW   <= 1'b0;
    end else begin
      KB_PARITY_ERR <= par_err_ev |
                       (KB_PARITY_ERR & ~KB_ERR_CLR);
      KB_FRAME_ERR  <= frm_err_ev |
                       (KB_FRAME_ERR & ~KB_ERR_CLR);
      KB_OVERFLOW   <= ovf_ev |
                       (KB_OVERFLOW & ~KB_ERR_CLR);
    end
  end

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Bench for ps2_kb_rx: key-event model with a per-cycle
// comparator plus literal checks on each directed scenario.
module tb_ps2_kb_rx;

  localparam int TMO   = 10000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kbclk = 1'b1;
  logic        kbdat = 1'b1;
  logic        ready = 1'b0;
  logic        err_clr = 1'b0;
  logic        kb_valid;
  logic [15:0] kb_data;
  logic        kb_par_err;
  logic        kb_frm_err;
  logic        kb_ovf;

  ps2_kb_rx #(
    .SYNC_STAGES(2),
    .FILTER_LEN (8),
    .TIMEOUT_CYC(TMO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLOCK_50     (clk),
    .RESET_N      (rst_n),
    .PS2_KBCLK    (kbclk),
    .PS2_KBDAT    (kbdat),
    .KB_VALID     (kb_valid),
    .KB_READY     (ready),
    .KB_DATA      (kb_data),
    .KB_PARITY_ERR(kb_par_err),
    .KB_FRAME_ERR (kb_frm_err),
    .KB_OVERFLOW  (kb_ovf),
    .KB_ERR_CLR   (err_clr)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] pop_log[$];
  bit m_par, m_frm, m_ovf, m_ext, m_brk;
  bit chk_en = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%h required=%h",
                 nm, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model of one completed frame, from the protocol rules.
  task automatic model_frame(input logic [7:0] code,
                             input logic par,
                             input logic stop);
    bit good;
    good = (^{code, par}) == 1'b1;
    if (!stop) m_frm = 1'b1;
    if (!good) m_par = 1'b1;
    if (stop && good) begin
      if (code == 8'hE0) begin
        m_ext = 1'b1;
      end else if (code == 8'hF0) begin
        m_brk = 1'b1;
      end else begin
        if (exp_q.size() < DEPTH)
          exp_q.push_back({m_brk, 6'b0, m_ext, code});
        else
          m_ovf = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end else begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] code,
                            input bit bad_par,
                            input bit stop);
    logic [10:0] f;
    logic par;
    par = (~^code) ^ bad_par;
    f = {stop, par, code, 1'b0};
    chk_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      kbdat = f[i];
      wait_cyc(20);
      kbclk = 1'b0;
      if (i == 10) model_frame(code, par, stop);
      wait_cyc(40);
      kbclk = 1'b1;
      wait_cyc(20);
    end
    kbdat = 1'b1;
    wait_cyc(10);
    chk_en = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] code,
                              input int nbits);
    logic [8:0] f;
    f = {code, 1'b0};
    chk_en = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      kbdat = f[i];
      wait_cyc(20);
      kbclk = 1'b0;
      wait_cyc(40);
      kbclk = 1'b1;
      wait_cyc(20);
    end
    kbdat = 1'b1;
  endtask

  task automatic clear_errs();
    chk_en = 1'b0;
    err_clr = 1'b1;
    m_par = 1'b0;
    m_frm = 1'b0;
    m_ovf = 1'b0;
    wait_cyc(1);
    err_clr = 1'b0;
    wait_cyc(2);
    chk_en = 1'b1;
  endtask

  task automatic expect_pops(input string nm,
                             input int n,
                             input logic [63:0] words);
    logic [15:0] a;
    check({nm, "_npop"}, pop_log.size(), n);
    for (int i = 0; i < n; i++) begin
      a = (i < pop_log.size()) ? pop_log[i] : 16'hxxxx;
      check({nm, "_word"}, a, words[16*i +: 16]);
    end
  endtask

  // Per-cycle comparator against the model, plus pop scoring.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_en) begin
        check("valid", kb_valid, exp_q.size() != 0);
        if (exp_q.size() != 0)
          check("data", kb_data, exp_q[0]);
        check("par_err", kb_par_err, m_par);
        check("frm_err", kb_frm_err, m_frm);
        check("ovf", kb_ovf, m_ovf);
      end
      if (kb_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", kb_data, 32'hxxxx_xxxx);
          pop_log.push_back(kb_data);
        end else begin
          check("pop_word", kb_data, exp_q[0]);
          pop_log.push_back(kb_data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    wait_cyc(5);
    check("rst_valid", kb_valid, 1'b0);
    check("rst_data", kb_data, 16'h0000);
    check("rst_par", kb_par_err, 1'b0);
    check("rst_frm", kb_frm_err, 1'b0);
    check("rst_ovf", kb_ovf, 1'b0);
    rst_n = 1'b1;
    wait_cyc(20);
    chk_en = 1'b1;

    // Single make code.
    ready = 1'b1;
    pop_log.delete();
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_cyc(10);
    expect_pops("make", 1, 64'h001C);
    check("make_par", kb_par_err, 1'b0);
    check("make_frm", kb_frm_err, 1'b0);

    // Break, then extended break.
    pop_log.delete();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    wait_cyc(10);
    expect_pops("brk", 2, {32'h0, 16'h8175, 16'h801C});

    // Parity error, then clear.
    pop_log.delete();
    send_frame(8'h1C, 1'b1, 1'b1);
    wait_cyc(10);
    expect_pops("perr", 0, 64'h0);
    check("perr_flag", kb_par_err, 1'b1);
    clear_errs();
    check("perr_clr", kb_par_err, 1'b0);

    // Bad stop bit.
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_cyc(5);
    check("stop_flag", kb_frm_err, 1'b1);
    expect_pops("stop", 0, 64'h0);
    clear_errs();

    // Timeout mid-frame, then recovery.
    send_partial(8'h1C, 6);
    wait_cyc(TMO + 10);
    m_frm = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    chk_en = 1'b1;
    wait_cyc(2);
    check("tmo_flag", kb_frm_err, 1'b1);
    pop_log.delete();
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_cyc(10);
    expect_pops("tmo_rec", 1, 64'h001C);
    clear_errs();

    // Overflow with the consumer stalled.
    ready = 1'b0;
    send_frame(8'h15, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b1);
    send_frame(8'h24, 1'b0, 1'b1);
    send_frame(8'h2D, 1'b0, 1'b1);
    send_frame(8'h2C, 1'b0, 1'b1);
    wait_cyc(5);
    check("ovf_flag", kb_ovf, 1'b1);
    check("ovf_head", kb_data, 16'h0015);
    pop_log.delete();
    ready = 1'b1;
    wait_cyc(10);
    expect_pops("ovf", 4,
                {16'h002D, 16'h0024, 16'h001D, 16'h0015});
    check("ovf_empty", kb_valid, 1'b0);
    check("ovf_sticky", kb_ovf, 1'b1);
    clear_errs();

    // Short clock glitch with data low in idle.
    chk_en = 1'b0;
    kbdat = 1'b0;
    wait_cyc(20);
    kbclk = 1'b0;
    wait_cyc(3);
    kbclk = 1'b1;
    wait_cyc(30);
    kbdat = 1'b1;
    wait_cyc(20);
    chk_en = 1'b1;
    pop_log.delete();
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_cyc(10);
    expect_pops("glitch", 1, 64'h001C);
    check("glitch_frm", kb_frm_err, 1'b0);

    // Reset in the middle of a frame.
    ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    send_partial(8'h24, 4);
    rst_n = 1'b0;
    kbclk = 1'b1;
    kbdat = 1'b1;
    exp_q.delete();
    m_par = 1'b0;
    m_frm = 1'b0;
    m_ovf = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    wait_cyc(3);
    check("mrst_valid", kb_valid, 1'b0);
    check("mrst_data", kb_data, 16'h0000);
    check("mrst_par", kb_par_err, 1'b0);
    check("mrst_frm", kb_frm_err, 1'b0);
    check("mrst_ovf", kb_ovf, 1'b0);
    rst_n = 1'b1;
    wait_cyc(20);
    chk_en = 1'b1;
    ready = 1'b1;
    pop_log.delete();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_cyc(10);
    expect_pops("mrst", 1, 64'h011C);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
